fetch_if_id: RTL and testbench

//  Instruction-fetch control plus IF/ID pipeline register. Sits directly downstream of the pc block.

---
 rtl/fetch_if_id_pkg.sv | 27 ++
 rtl/fetch_if_id_reg.sv | 35 +++
 rtl/fetch_if_id.sv | 171 +++++++++++++++++
 tb/tb_fetch_if_id.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_if_id_pkg.sv
// Shared types and constants for the instruction-fetch / IF-ID stage.
package fetch_if_id_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_INC    = 16'h0002;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 16'h0000, pc_plus2: 16'h0000, valid: 1'b0};

  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// 49-bit {instr, pc, pc_plus2, valid} register with clear/load/hold; used for IF/ID and the HOLD buffer.
module fetch_if_id_reg
  import fetch_if_id_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clear_i,
  input  logic   load_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q, q_d;

  // Clear wins over load so a flush always leaves a bubble behind.
  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d = IF_ID_BUBBLE;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= IF_ID_BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction-fetch controller plus IF/ID pipeline register, between the pc block and decode.
//   state     | meaning
//   ST_FETCH  | issue read at pc_i this cycle; hit accepts immediately
//   ST_WAIT   | read outstanding at req_pc_q; squash drops the returning word
//   ST_HOLD   | accepted word parked in buffer until decode frees up
//   ST_HALTED | fetching stopped, IF/ID frozen until reset
module fetch_if_id
  import fetch_if_id_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] pc_i,
  input  logic        flush_i,
  input  logic        dec_stall_i,
  input  logic        halt_i,
  output logic [15:0] imem_addr_o,
  output logic        imem_rd_o,
  input  logic [15:0] imem_data_i,
  input  logic        imem_done_i,
  output logic        pc_stall_o,
  output logic [15:0] instr_o,
  output logic [15:0] pc_o,
  output logic [15:0] pc_plus2_o,
  output logic        valid_o,
  output logic        err_o
);

  fetch_state_e state_q, state_d;
  logic [15:0]  req_pc_q, req_pc_d;
  logic         squash_q, squash_d;
  logic         halt_pend_q, halt_pend_d;
  logic         err_q, err_d;
  logic         accept, halt_any;
  logic         ifid_load, ifid_clear, buf_load, buf_clear;
  logic [15:0]  acc_pc;
  if_id_t       fetched, ifid_d, ifid_q, buf_q;

  assign acc_pc   = (state_q == ST_FETCH) ? pc_i : req_pc_q;
  assign fetched  = '{instr: imem_data_i, pc: acc_pc, pc_plus2: pc_next(acc_pc), valid: 1'b1};
  assign ifid_d   = (state_q == ST_HOLD) ? buf_q : fetched;
  assign halt_any = halt_i | halt_pend_q;

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    squash_d    = squash_q;
    halt_pend_d = halt_pend_q;
    err_d       = err_q;
    imem_rd_o   = 1'b0;
    imem_addr_o = req_pc_q;
    pc_stall_o  = 1'b1;
    accept      = 1'b0;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;

    if (!rst_i) begin
      case (state_q)
        ST_FETCH: begin
          imem_rd_o   = 1'b1;
          imem_addr_o = pc_i;
          req_pc_d    = pc_i;
          if (flush_i) begin
            if (!imem_done_i) begin
              squash_d = 1'b1;
              state_d  = ST_WAIT;
            end
          end else if (imem_done_i) begin
            accept = 1'b1;
          end else begin
            state_d = ST_WAIT;
            if (halt_i) halt_pend_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            squash_d = !imem_done_i;
            if (imem_done_i) state_d = ST_FETCH;
          end else if (imem_done_i && squash_q) begin
            squash_d = 1'b0;
            state_d  = halt_any ? ST_HALTED : ST_FETCH;
          end else if (imem_done_i) begin
            accept = 1'b1;
          end else if (halt_i) begin
            halt_pend_d = 1'b1;
          end
        end
        ST_HOLD: begin
          err_d = err_q | imem_done_i;
          if (flush_i) begin
            state_d = ST_FETCH;
          end else if (!dec_stall_i) begin
            ifid_load = 1'b1;
            state_d   = halt_any ? ST_HALTED : ST_FETCH;
          end else if (halt_i) begin
            halt_pend_d = 1'b1;
          end
        end
        ST_HALTED: begin
          err_d = err_q | imem_done_i;
        end
        default: ;
      endcase

      // The only cycle pc may advance is the one where a fetched word is taken.
      if (accept) begin
        pc_stall_o = 1'b0;
        if (!dec_stall_i) begin
          ifid_load = 1'b1;
          state_d   = halt_any ? ST_HALTED : ST_FETCH;
        end else begin
          buf_load = 1'b1;
          state_d  = ST_HOLD;
          if (halt_i) halt_pend_d = 1'b1;
        end
      end

      if (state_q != ST_HALTED) begin
        if (flush_i) begin
          ifid_clear  = 1'b1;
          buf_clear   = 1'b1;
          halt_pend_d = 1'b0;
        end else if (!ifid_load && !dec_stall_i) begin
          ifid_clear = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_FETCH;
      req_pc_q    <= 16'h0000;
      squash_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_pc_q    <= req_pc_d;
      squash_q    <= squash_d;
      halt_pend_q <= halt_pend_d;
      err_q       <= err_d;
    end
  end

  fetch_if_id_reg u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (ifid_clear),
    .load_i  (ifid_load),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  fetch_if_id_reg u_hold_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (buf_clear),
    .load_i  (buf_load),
    .d_i     (fetched),
    .q_o     (buf_q)
  );

  assign instr_o    = ifid_q.instr;
  assign pc_o       = ifid_q.pc;
  assign pc_plus2_o = ifid_q.pc_plus2;
  assign valid_o    = ifid_q.valid;
  assign err_o      = err_q;

endmodule

// File: tb/tb_fetch_if_id.sv
// Self-checking bench for fetch_if_id: directed scenarios plus a randomized run against a stream model.
module tb_fetch_if_id;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        flush = 1'b0, dec_stall = 1'b0, halt = 1'b0, done = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [15:0] imem_addr_o, instr_o, pc_o, pc_plus2_o;
  logic        imem_rd_o, pc_stall_o, valid_o, err_o;
  int          tests_run = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  fetch_if_id dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pc_i        (pc),
    .flush_i     (flush),
    .dec_stall_i (dec_stall),
    .halt_i      (halt),
    .imem_addr_o (imem_addr_o),
    .imem_rd_o   (imem_rd_o),
    .imem_data_i (data),
    .imem_done_i (done),
    .pc_stall_o  (pc_stall_o),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .pc_plus2_o  (pc_plus2_o),
    .valid_o     (valid_o),
    .err_o       (err_o)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic d, input logic [15:0] dat,
                       input logic ds, input logic fl, input logic hl);
    pc = p; done = d; data = dat; dec_stall = ds; flush = fl; halt = hl;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imem_rd_o !== 1'b0) begin failed++; $display("FAIL rst_rd got %b want 0", imem_rd_o); end
    tests_run++; if (pc_stall_o !== 1'b1) begin failed++; $display("FAIL rst_stall got %b want 1", pc_stall_o); end
    tick();
    tick();
    tests_run++; if (valid_o !== 1'b0) begin failed++; $display("FAIL rst_valid got %b want 0", valid_o); end
    tests_run++; if (instr_o !== NOP) begin failed++; $display("FAIL rst_instr got %h want %h", instr_o, NOP); end
    tests_run++; if (pc_o !== 16'h0 || pc_plus2_o !== 16'h0) begin failed++; $display("FAIL rst_pc got %h/%h want 0/0", pc_o, pc_plus2_o); end
    tests_run++; if (err_o !== 1'b0) begin failed++; $display("FAIL rst_err got %b want 0", err_o); end
    rst = 1'b0;
  endtask

  task automatic test_hits();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      logic [15:0] a;
      a = 16'(2 * k);
      drive(a, 1'b1, mem_word(a), 1'b0, 1'b0, 1'b0);
      tests_run++; if (imem_rd_o !== 1'b1 || imem_addr_o !== a) begin failed++; $display("FAIL hit_req rd=%b addr=%h want 1/%h", imem_rd_o, imem_addr_o, a); end
      tests_run++; if (pc_stall_o !== 1'b0) begin failed++; $display("FAIL hit_stall got %b want 0", pc_stall_o); end
      tick();
      tests_run++; if (valid_o !== 1'b1 || pc_o !== a) begin failed++; $display("FAIL hit_ifid valid=%b pc=%h want 1/%h", valid_o, pc_o, a); end
      tests_run++; if (pc_plus2_o !== a + 16'd2 || instr_o !== mem_word(a)) begin failed++; $display("FAIL hit_data pc2=%h instr=%h want %h/%h", pc_plus2_o, instr_o, a + 16'd2, mem_word(a)); end
    end
  endtask

  task automatic test_miss();
    apply_reset();
    drive(16'h0010, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imem_rd_o !== 1'b1 || pc_stall_o !== 1'b1) begin failed++; $display("FAIL miss_issue rd=%b stall=%b want 1/1", imem_rd_o, pc_stall_o); end
    tick();
    for (int w = 0; w < 2; w++) begin
      drive(16'h0010, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b0);
      tests_run++; if (imem_rd_o !== 1'b0 || pc_stall_o !== 1'b1 || imem_addr_o !== 16'h0010) begin failed++; $display("FAIL miss_wait rd=%b stall=%b addr=%h want 0/1/0010", imem_rd_o, pc_stall_o, imem_addr_o); end
      tick();
      tests_run++; if (valid_o !== 1'b0) begin failed++; $display("FAIL miss_wait_valid got %b want 0", valid_o); end
    end
    drive(16'h0010, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    tests_run++; if (pc_stall_o !== 1'b0 || imem_rd_o !== 1'b0) begin failed++; $display("FAIL miss_done stall=%b rd=%b want 0/0", pc_stall_o, imem_rd_o); end
    tick();
    tests_run++; if (valid_o !== 1'b1 || instr_o !== 16'hBEEF || pc_o !== 16'h0010 || pc_plus2_o !== 16'h0012) begin failed++; $display("FAIL miss_ifid v=%b i=%h pc=%h pc2=%h want 1/beef/0010/0012", valid_o, instr_o, pc_o, pc_plus2_o); end
  endtask

  task automatic test_dec_stall();
    apply_reset();
    drive(16'h001E, 1'b1, mem_word(16'h001E), 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'h0020, 1'b1, mem_word(16'h0020), 1'b1, 1'b0, 1'b0);
    tests_run++; if (pc_stall_o !== 1'b0) begin failed++; $display("FAIL ds_accept_stall got %b want 0", pc_stall_o); end
    tick();
    for (int h = 0; h < 2; h++) begin
      tests_run++; if (valid_o !== 1'b1 || pc_o !== 16'h001E || instr_o !== mem_word(16'h001E)) begin failed++; $display("FAIL ds_hold_ifid v=%b pc=%h i=%h want 1/001e/%h", valid_o, pc_o, instr_o, mem_word(16'h001E)); end
      drive(16'h0022, 1'b0, 16'h0000, (h == 0), 1'b0, 1'b0);
      tests_run++; if (imem_rd_o !== 1'b0 || pc_stall_o !== 1'b1) begin failed++; $display("FAIL ds_hold_ctl rd=%b stall=%b want 0/1", imem_rd_o, pc_stall_o); end
      tick();
    end
    tests_run++; if (valid_o !== 1'b1 || pc_o !== 16'h0020 || instr_o !== mem_word(16'h0020)) begin failed++; $display("FAIL ds_release v=%b pc=%h i=%h want 1/0020/%h", valid_o, pc_o, instr_o, mem_word(16'h0020)); end
    drive(16'h0022, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0022) begin failed++; $display("FAIL ds_next_fetch rd=%b addr=%h want 1/0022", imem_rd_o, imem_addr_o); end
  endtask

  task automatic test_flush();
    apply_reset();
    drive(16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    drive(16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tests_run++; if (pc_stall_o !== 1'b1 || imem_rd_o !== 1'b0) begin failed++; $display("FAIL fl_wait stall=%b rd=%b want 1/0", pc_stall_o, imem_rd_o); end
    tick();
    drive(16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imem_rd_o !== 1'b0) begin failed++; $display("FAIL fl_still_wait rd=%b want 0", imem_rd_o); end
    tick();
    drive(16'h0100, 1'b1, mem_word(16'h0040), 1'b0, 1'b0, 1'b0);
    tests_run++; if (pc_stall_o !== 1'b1) begin failed++; $display("FAIL fl_drop_stall got %b want 1", pc_stall_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0) begin failed++; $display("FAIL fl_drop_valid got %b want 0", valid_o); end
    drive(16'h0100, 1'b1, mem_word(16'h0100), 1'b0, 1'b0, 1'b0);
    tests_run++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0100 || pc_stall_o !== 1'b0) begin failed++; $display("FAIL fl_redirect rd=%b addr=%h stall=%b want 1/0100/0", imem_rd_o, imem_addr_o, pc_stall_o); end
    tick();
    tests_run++; if (valid_o !== 1'b1 || pc_o !== 16'h0100) begin failed++; $display("FAIL fl_redirect_ifid v=%b pc=%h want 1/0100", valid_o, pc_o); end
    drive(16'h0102, 1'b1, mem_word(16'h0102), 1'b1, 1'b1, 1'b0);
    tests_run++; if (pc_stall_o !== 1'b1) begin failed++; $display("FAIL fl_hit_stall got %b want 1", pc_stall_o); end
    tick();
    tests_run++; if (valid_o !== 1'b0 || instr_o !== NOP) begin failed++; $display("FAIL fl_hit_bubble v=%b i=%h want 0/%h", valid_o, instr_o, NOP); end
    drive(16'h0102, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++; if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0102) begin failed++; $display("FAIL fl_refetch rd=%b addr=%h want 1/0102", imem_rd_o, imem_addr_o); end
    tick();
    drive(16'h0102, 1'b1, mem_word(16'h0102), 1'b0, 1'b0, 1'b0);
    tests_run++; if (pc_stall_o !== 1'b0) begin failed++; $display("FAIL fl_no_stale_squash stall=%b want 0", pc_stall_o); end
    tick();
    tests_run++; if (valid_o !== 1'b1 || pc_o !== 16'h0102) begin failed++; $display("FAIL fl_refetch_ifid v=%b pc=%h want 1/0102", valid_o, pc_o); end
  endtask

  task automatic test_halt();
    apply_reset();
    drive(16'h0030, 1'b1, mem_word(16'h0030), 1'b0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(16'($urandom) & 16'hFFFE, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tests_run++; if (imem_rd_o !== 1'b0 || pc_stall_o !== 1'b1) begin failed++; $display("FAIL halt_ctl cyc=%0d rd=%b stall=%b want 0/1", c, imem_rd_o, pc_stall_o); end
      tests_run++; if (valid_o !== 1'b1 || pc_o !== 16'h0030 || pc_plus2_o !== 16'h0032 || instr_o !== mem_word(16'h0030)) begin failed++; $display("FAIL halt_frozen cyc=%0d v=%b pc=%h pc2=%h i=%h", c, valid_o, pc_o, pc_plus2_o, instr_o); end
      tick();
    end
    apply_reset();
    drive(16'h0050, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tests_run++; if (valid_o !== 1'b0 || imem_rd_o !== 1'b1) begin failed++; $display("FAIL halt_exit v=%b rd=%b want 0/1", valid_o, imem_rd_o); end
  endtask

  task automatic test_err();
    apply_reset();
    drive(16'hFFFE, 1'b1, mem_word(16'hFFFE), 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++; if (pc_o !== 16'hFFFE || pc_plus2_o !== 16'h0000) begin failed++; $display("FAIL wrap pc=%h pc2=%h want fffe/0000", pc_o, pc_plus2_o); end
    drive(16'h0000, 1'b1, mem_word(16'h0000), 1'b1, 1'b0, 1'b0);
    tick();
    tests_run++; if (err_o !== 1'b0) begin failed++; $display("FAIL err_pre got %b want 0", err_o); end
    drive(16'h0002, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      tests_run++; if (err_o !== 1'b1) begin failed++; $display("FAIL err_sticky cyc=%0d got %b want 1", c, err_o); end
      drive(16'h0002, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply_reset();
    tests_run++; if (err_o !== 1'b0) begin failed++; $display("FAIL err_clear got %b want 0", err_o); end
  endtask

  // Decode must see the words at consecutive PCs, in order, no matter how
  // memory latency and decode stalls interleave.
  task automatic test_random();
    logic [15:0] pc_q, exp_pc, req;
    logic        busy, stall_s;
    int          rem, consumed;
    apply_reset();
    pc_q     = 16'($urandom) & 16'hFFFE;
    exp_pc   = pc_q;
    busy     = 1'b0;
    rem      = 0;
    consumed = 0;
    req      = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      drive(pc_q, 1'b0, 16'($urandom), ($urandom_range(0, 9) < 3), 1'b0, 1'b0);
      if (imem_rd_o) begin
        tests_run++; if (busy || imem_addr_o !== pc_q) begin failed++; $display("FAIL rand_req cyc=%0d busy=%b addr=%h want 0/%h", c, busy, imem_addr_o, pc_q); end
        req = imem_addr_o;
        rem = $urandom_range(0, 3);
        if (rem == 0) begin
          done = 1'b1; data = mem_word(req);
        end else begin
          busy = 1'b1;
        end
      end else if (busy) begin
        rem--;
        if (rem == 0) begin
          busy = 1'b0; done = 1'b1; data = mem_word(req);
        end
      end
      #1;
      if (valid_o && !dec_stall) begin
        tests_run++; if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc) || pc_plus2_o !== exp_pc + 16'd2) begin failed++; $display("FAIL rand_stream cyc=%0d pc=%h i=%h pc2=%h want %h/%h/%h", c, pc_o, instr_o, pc_plus2_o, exp_pc, mem_word(exp_pc), exp_pc + 16'd2); end
        exp_pc = exp_pc + 16'd2;
        consumed++;
      end
      stall_s = pc_stall_o;
      tick();
      if (!stall_s) pc_q = pc_q + 16'd2;
    end
    tests_run++; if (consumed < 200) begin failed++; $display("FAIL rand_throughput got %0d want >=200", consumed); end
    tests_run++; if (err_o !== 1'b0) begin failed++; $display("FAIL rand_err got %b want 0", err_o); end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_dec_stall();
    test_flush();
    test_halt();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
